// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage.
// Holds the FSM state encoding, PC increment and NOP encoding.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam int unsigned PC_INC = 4;

  // Decode substitutes this when the slot is empty.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline slot: valid bit, instruction and its PC.
// Ports: clk, reset, i_load, i_flush, i_id_ready, i_instr, i_pc,
//        o_valid, o_instr, o_pc.
module if_id_reg #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic              i_id_ready,
  input  logic [31:0]       i_instr,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              o_valid,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_pc
);

  logic              r_valid;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pc;

  // Flush beats load and handshake; an unreplaced
  // slot empties once decode takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_id_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// PC generation, redirect/halt FSM and IF/ID slot feeding decode.
// Ports: clk, reset, imem_addr/imem_instr, redirect_valid/redirect_pc,
//   halt_req, resume, id_ready, if_valid/if_instr/if_pc, halted,
//   fetch_err; fetch_count only when FETCH_CNT_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter int                 IMEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              id_ready,
`ifdef FETCH_CNT_EN
  output logic [31:0]       fetch_count,
`endif
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted,
  output logic              fetch_err
);

  localparam logic [ADDR_W-1:0] PC_LIMIT =
    ADDR_W'(IMEM_DEPTH * 4);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              w_load;
  logic              w_flush;
  logic              w_redir;
  logic              w_oor;
  logic              w_valid;

  assign w_redir = redirect_valid && (r_state != ST_BOOT);
  assign w_oor   = (r_pc >= PC_LIMIT);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_err_nxt   = r_err;
    w_load      = 1'b0;
    w_flush     = 1'b0;
    unique case (r_state)
      ST_BOOT: w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (w_redir) begin
          if (halt_req) w_state_nxt = ST_HALT;
        end else if (halt_req) begin
          w_state_nxt = ST_HALT;
        end else if (w_oor) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_HALT;
        end else if (!w_valid || id_ready) begin
          w_load   = 1'b1;
          w_pc_nxt = r_pc + ADDR_W'(PC_INC);
        end
      end
      ST_HALT: begin
        if (resume && !halt_req) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_BOOT;
    endcase
    if (w_redir) begin
      w_flush  = 1'b1;
      w_pc_nxt = {redirect_pc[ADDR_W-1:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) w_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_err   <= w_err_nxt;
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W)
  ) u_slot (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_id_ready (id_ready),
    .i_instr    (imem_instr),
    .i_pc       (r_pc),
    .o_valid    (w_valid),
    .o_instr    (if_instr),
    .o_pc       (if_pc)
  );

`ifdef FETCH_CNT_EN
  logic [31:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (w_load) r_cnt <= r_cnt + 32'd1;
  end

  assign fetch_count = r_cnt;
`endif

  assign imem_addr = r_pc;
  assign if_valid  = w_valid;
  assign halted    = (r_state == ST_HALT);
  assign fetch_err = r_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage against a cycle-level model.
// Directed scenarios followed by randomized traffic.
module tb_fetch_stage;

  localparam logic [31:0] LIMIT = 32'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        halted;
  logic        fetch_err;
`ifdef FETCH_CNT_EN
  logic [31:0] fetch_count;
`endif

  always #5 clk = ~clk;

  // Instruction memory: word at byte address a holds a + 0x100.
  assign imem_instr = imem_addr + 32'h100;

  fetch_stage #(
    .ADDR_W     (32),
    .RESET_PC   (32'h0),
    .IMEM_DEPTH (1024)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .resume         (resume),
    .id_ready       (id_ready),
`ifdef FETCH_CNT_EN
    .fetch_count    (fetch_count),
`endif
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .halted         (halted),
    .fetch_err      (fetch_err)
  );

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Reference model: mode 0 = booting, 1 = running, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_err;
  logic [31:0] m_cnt;
  logic [63:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Apply the rules for one rising edge, using the inputs
  // that were stable across that edge.
  task automatic model_edge();
    bit redir, running_free, load, oor;
    if (reset) begin
      m_mode = 0; m_pc = 32'h0; m_valid = 0;
      m_err = 0; m_cnt = 0;
      exp_q.delete();
      return;
    end
    redir = redirect_valid && (m_mode != 0);
    running_free = (m_mode == 1) && !redir && !halt_req;
    oor  = running_free && (m_pc >= LIMIT);
    load = running_free && !oor && (!m_valid || id_ready);
    if (redir) begin
      if (m_valid && exp_q.size() > 0) void'(exp_q.pop_back());
      m_valid = 0;
      if (redirect_pc[1:0] != 0) m_err = 1;
    end else if (load) begin
      exp_q.push_back({m_pc + 32'h100, m_pc});
      m_valid = 1;
      m_cnt++;
    end else if (m_valid && id_ready) begin
      m_valid = 0;
    end
    if (oor) m_err = 1;
    case (m_mode)
      0: m_mode = 1;
      1: if (halt_req || oor) m_mode = 2;
      default: if (resume && !halt_req) m_mode = 1;
    endcase
    if (redir) m_pc = redirect_pc & 32'hFFFF_FFFC;
    else if (load) m_pc = m_pc + 4;
  endtask

  task automatic cyc(input logic rst, input logic rv,
                     input logic [31:0] rp, input logic hr,
                     input logic rs, input logic rdy);
    reset = rst; redirect_valid = rv; redirect_pc = rp;
    halt_req = hr; resume = rs; id_ready = rdy;
    @(posedge clk);
    model_edge();
    started = 1;
    #1;
  endtask

  // Monitor: sample between edges, pop on each handshake.
  always @(negedge clk) begin
    logic [63:0] e;
    if (started) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
      chk("halted", {31'b0, halted}, {31'b0, m_mode == 2});
      chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
`ifdef FETCH_CNT_EN
      chk("fetch_count", fetch_count, m_cnt);
`endif
      if (m_mode == 0) begin
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
      end
      if (if_valid && id_ready && !redirect_valid && !reset) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL handshake got=%h want=none", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("if_pc", if_pc, e[31:0]);
          chk("if_instr", if_instr, e[63:32]);
        end
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    // Reset, then free-running fetch.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
    // Stall with if_pc = 8, then release.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    // Redirect during stall, then misaligned redirect.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h40, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 32'h42, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1);
    // Halt with a held slot, drain it, then resume.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    // Redirect together with halt, then resume at target.
    cyc(0, 1, 32'h200, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    // Last legal word, then out of range and re-halt.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 32'hFF8, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    // Redirect back in range from halt, resume, then reset mid-stall.
    cyc(0, 1, 32'h80, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0: tgt = 32'hFFC;
        1: tgt = 32'h1000;
        2: tgt = $urandom;
        3: tgt = ($urandom_range(0, 1023) << 2) | $urandom_range(1, 3);
        default: tgt = $urandom_range(0, 1023) << 2;
      endcase
      cyc($urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 8, tgt,
          $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 70);
    end
    cyc(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
